cpu_fetch_unit: RTL and testbench
=================================

CPU_FETCH_UNIT -- requirements
Module: cpu_fetch_unit

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12, master clocks per bus cycle (legal range 2..31).
REQ-002 SHALL have parameter RESET_VEC, default 16'hFFFC, reset vector low-byte address.
REQ-003 SHALL have parameter NMI_VEC, default 16'hFFFA, NMI vector low-byte address.
REQ-004 SHALL have parameter IRQ_VEC, default 16'hFFFE, IRQ vector low-byte address.
REQ-005 SHALL have port clock  input  1  21.47727 MHz master clock, the only clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port irq  input  1  active-low level interrupt request.
REQ-008 SHALL have port nmi  input  1  active-low non-maskable interrupt, falling-edge sensitive.
REQ-009 SHALL have port dataIn  input  8  read data bus.
REQ-010 SHALL have port irq_mask  input  1  I flag from execute stage; 1 blocks IRQ.
REQ-011 SHALL have port exec_done  input  1  execute stage accepts the issued instruction.
REQ-012 SHALL have port pc_load  input  1  qualifies pc_new when exec_done=1.
REQ-013 SHALL have port pc_new  input  16  next PC for jumps and branches.
REQ-014 SHALL have port addressOut  output  16  bus address.
REQ-015 SHALL have port rw  output  1  constant 1 (read only).
REQ-016 SHALL have port tick  output  1  one-clock bus-cycle strobe.
REQ-017 SHALL have port instr_valid  output  1  opcode/operand/pc_out valid.
REQ-018 SHALL have port opcode  output  8  fetched opcode.
REQ-019 SHALL have port operand  output  16  operand bytes, little-endian, unused bytes 0.
REQ-020 SHALL have port pc_out  output  16  address of opcode, or vector target for interrupts.
REQ-021 SHALL have port int_kind  output  2  00 none, 01 NMI, 10 IRQ, 11 reset entry.

Function
REQ-022 tick SHALL pulse high for one clock every CLK_DIV clocks; all state changes and dataIn captures SHALL occur only on tick.
REQ-023 States SHALL be VEC_LO, VEC_HI, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE.
REQ-024 VEC_LO SHALL drive the vector address and capture the PC low byte; VEC_HI SHALL drive vector+1, capture the high byte and go to ISSUE with opcode 0, instr_valid=1 and int_kind set.
REQ-025 FETCH_OP SHALL drive PC, capture opcode and increment PC; next state SHALL be FETCH_B1 if op_len>0, else ISSUE.
REQ-026 FETCH_B1 and FETCH_B2 SHALL each drive PC, capture one byte and increment PC; FETCH_B1 SHALL go to FETCH_B2 if op_len=2, else ISSUE.
REQ-027 op_len, with cc=op[1:0] and bbb=op[4:2]: cc=11 gives 0; cc=01 gives 2 for bbb in {011,110,111}, else 1; cc=00/10 gives 2 for bbb in {011,111}, 0 for bbb in {010,110}, 1 otherwise; exceptions 0x00/0x40/0x60 give 0, 0x20 gives 2, cc=10 bbb=100 gives 0.
REQ-028 ISSUE SHALL hold instr_valid=1 and all outputs stable until exec_done=1, sampled on any clock edge and latched until the next tick.
REQ-029 On the tick after acceptance, PC SHALL become pc_new if pc_load was 1, else remain PC.
REQ-030 After acceptance: pending NMI gives VEC_LO(NMI_VEC); else irq=0 with irq_mask=0 gives VEC_LO(IRQ_VEC); else FETCH_OP.
REQ-031 When NMI and IRQ are both pending, NMI SHALL win and IRQ SHALL be re-evaluated after the NMI issue.
REQ-032 A falling nmi edge SHALL set the NMI pending flag on any clock; entering VEC_LO(NMI) SHALL clear it, and an edge arriving in that same clock SHALL remain pending.
REQ-033 PC increment SHALL wrap modulo 2^16 (FFFF to 0000), and vector+1 SHALL likewise wrap.
REQ-034 instr_valid SHALL be 0 in every state except ISSUE.

Reset
REQ-035 When reset=0: state=VEC_LO (RESET_VEC), divider=0, PC=0, instr_valid=0, opcode=0, operand=0, pc_out=0, int_kind=00, NMI pending=0, addressOut=RESET_VEC, rw=1, tick=0.
REQ-036 Reset asserted mid-fetch or during ISSUE SHALL abort immediately; after release the first tick SHALL occur CLK_DIV clocks later.

Configuration
REQ-037 With NESCPU_IRQ_EN defined, IRQ SHALL be serviced per REQ-030; without it, irq and irq_mask SHALL be ignored, int_kind SHALL never be 10, and the ports SHALL remain present.

Structure
REQ-038 Package nes_cpu_pkg SHALL hold the state enum, the int_kind encoding, the default vector constants and the op_len function.
REQ-039 Sub-module cpu_clk_div (parameter CLK_DIV; ports clock, reset, tick) SHALL generate tick.

Verification
REQ-040 Reset release, dataIn=34 at FFFC and 12 at FFFD -> ISSUE with pc_out=1234, int_kind=11, first tick at clock 12.
REQ-041 Memory 8000: AD 00 20 and exec_done -> ISSUE opcode=AD, operand=2000, pc_out=8000, 3 ticks; next fetch at 8003.
REQ-042 EA at FFFF -> opcode EA, operand 0000, next fetch address 0000 (wrap).
REQ-043 nmi falling and irq=0, irq_mask=0 during ISSUE -> VEC FFFA/FFFB, int_kind=01; then IRQ VEC FFFE/FFFF, int_kind=10; without NESCPU_IRQ_EN -> FETCH_OP instead.
REQ-044 exec_done with pc_load=1, pc_new=C000 -> next addressOut=C000; exec_done held 0 for 50 clocks -> outputs stable and no bus advance.
REQ-045 reset pulsed low during FETCH_B1 -> all outputs at reset values within the same clock; refetch begins from FFFC.

Source files
------------

// File: rtl/nes_cpu_pkg.sv
// Shared definitions for the CPU fetch unit: FSM state codes, interrupt-kind
// encoding, default vector addresses and the 6502 instruction length decoder.
package nes_cpu_pkg;

    // Fetch FSM states
    localparam logic [2:0] ST_VEC_LO   = 3'd0;
    localparam logic [2:0] ST_VEC_HI   = 3'd1;
    localparam logic [2:0] ST_FETCH_OP = 3'd2;
    localparam logic [2:0] ST_FETCH_B1 = 3'd3;
    localparam logic [2:0] ST_FETCH_B2 = 3'd4;
    localparam logic [2:0] ST_ISSUE    = 3'd5;

    // int_kind encoding reported alongside an issued item
    localparam logic [1:0] INT_NONE  = 2'b00;
    localparam logic [1:0] INT_NMI   = 2'b01;
    localparam logic [1:0] INT_IRQ   = 2'b10;
    localparam logic [1:0] INT_RESET = 2'b11;

    // Default vector low-byte addresses
    localparam logic [15:0] DEF_RESET_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_NMI_VEC   = 16'hFFFA;
    localparam logic [15:0] DEF_IRQ_VEC   = 16'hFFFE;

    // Number of operand bytes following an opcode.
    // BRK/RTI/RTS are treated as single-byte, JSR carries an absolute address.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [1:0] len;
        cc  = op[1:0];
        bbb = op[4:2];
        if (op == 8'h00 || op == 8'h40 || op == 8'h60)
            len = 2'd0;
        else if (op == 8'h20)
            len = 2'd2;
        else if (cc == 2'b11)
            len = 2'd0;
        else if (cc == 2'b10 && bbb == 3'b100)
            len = 2'd0;
        else if (cc == 2'b01)
            len = (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) ? 2'd2 : 2'd1;
        else if (bbb == 3'b011 || bbb == 3'b111)
            len = 2'd2;
        else if (bbb == 3'b010 || bbb == 3'b110)
            len = 2'd0;
        else
            len = 2'd1;
        return len;
    endfunction

endpackage

// File: rtl/cpu_clk_div.sv
// Bus-cycle divider: produces a one-clock tick every CLK_DIV master clocks.
// After reset release the first tick is high during the CLK_DIV-th clock.
module cpu_clk_div #(
    parameter int CLK_DIV = 12
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam logic [4:0] LAST    = 5'(CLK_DIV - 1);
    localparam logic [4:0] PRE_LST = 5'(CLK_DIV - 2);

    logic [4:0] cnt;

    // Free-running modulo-CLK_DIV counter with a registered tick one step ahead
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt  <= 5'd0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
            tick <= (cnt == PRE_LST);
        end
    end

endmodule

// File: rtl/cpu_fetch_unit.sv
// 6502-style instruction fetch unit. Reads vectors and instruction bytes one
// bus cycle at a time, then presents a decoded-length instruction (or an
// interrupt entry) to the execute stage and waits for acceptance.
// Optional build macro: NESCPU_IRQ_EN enables servicing of the irq input.
module cpu_fetch_unit
    import nes_cpu_pkg::*;
#(
    parameter int          CLK_DIV   = 12,
    parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [15:0] NMI_VEC   = DEF_NMI_VEC,
    parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        irq,
    input  logic        nmi,
    input  logic [7:0]  dataIn,
    input  logic        irq_mask,
    input  logic        exec_done,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    output logic [15:0] addressOut,
    output logic        rw,
    output logic        tick,
    output logic        instr_valid,
    output logic [7:0]  opcode,
    output logic [15:0] operand,
    output logic [15:0] pc_out,
    output logic [1:0]  int_kind
);

    logic [2:0]  state;
    logic [15:0] pc;
    logic [15:0] vec;
    logic [1:0]  vec_kind;
    logic        nmi_prev;
    logic        nmi_pend;
    logic        nmi_fall;
    logic        acc;
    logic        acc_load;
    logic [15:0] acc_pc;
    logic        go;
    logic        use_load;
    logic [15:0] load_pc;
    logic        leave_issue;
    logic        enter_nmi;
    logic        irq_take;

    cpu_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

`ifdef NESCPU_IRQ_EN
    assign irq_take = ~irq & ~irq_mask;
`else
    logic irq_unused;
    assign irq_unused = irq | irq_mask;
    assign irq_take   = 1'b0;
`endif

    assign rw          = 1'b1;
    assign nmi_fall    = nmi_prev & ~nmi;
    assign go          = acc | exec_done;
    assign use_load    = acc ? acc_load : pc_load;
    assign load_pc     = acc ? acc_pc : pc_new;
    assign leave_issue = tick && (state == ST_ISSUE) && go;
    assign enter_nmi   = leave_issue && nmi_pend;

    // Bus address follows the current state; ISSUE parks on the next PC
    always_comb begin
        addressOut = pc;
        case (state)
            ST_VEC_LO: addressOut = vec;
            ST_VEC_HI: addressOut = vec + 16'd1;
            default:   addressOut = pc;
        endcase
    end

    // NMI falling-edge detector; a new edge wins over the clear in the same clock
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            nmi_prev <= 1'b1;
            nmi_pend <= 1'b0;
        end else begin
            nmi_prev <= nmi;
            nmi_pend <= (nmi_pend & ~enter_nmi) | nmi_fall;
        end
    end

    // Remember an acceptance seen between ticks along with its jump target
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc      <= 1'b0;
            acc_load <= 1'b0;
            acc_pc   <= 16'h0000;
        end else if (leave_issue) begin
            acc <= 1'b0;
        end else if (state == ST_ISSUE && exec_done && !acc) begin
            acc      <= 1'b1;
            acc_load <= pc_load;
            acc_pc   <= pc_new;
        end
    end

    // Fetch state machine, advancing once per bus cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_VEC_LO;
            vec         <= RESET_VEC;
            vec_kind    <= INT_RESET;
            pc          <= 16'h0000;
            instr_valid <= 1'b0;
            opcode      <= 8'h00;
            operand     <= 16'h0000;
            pc_out      <= 16'h0000;
            int_kind    <= INT_NONE;
        end else if (tick) begin
            case (state)
                ST_VEC_LO: begin
                    pc    <= {pc[15:8], dataIn};
                    state <= ST_VEC_HI;
                end
                ST_VEC_HI: begin
                    pc          <= {dataIn, pc[7:0]};
                    pc_out      <= {dataIn, pc[7:0]};
                    opcode      <= 8'h00;
                    operand     <= 16'h0000;
                    int_kind    <= vec_kind;
                    instr_valid <= 1'b1;
                    state       <= ST_ISSUE;
                end
                ST_FETCH_OP: begin
                    opcode   <= dataIn;
                    operand  <= 16'h0000;
                    pc_out   <= pc;
                    int_kind <= INT_NONE;
                    pc       <= pc + 16'd1;
                    if (op_len(dataIn) == 2'd0) begin
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end else begin
                        state <= ST_FETCH_B1;
                    end
                end
                ST_FETCH_B1: begin
                    operand[7:0] <= dataIn;
                    pc           <= pc + 16'd1;
                    if (op_len(opcode) == 2'd2) begin
                        state <= ST_FETCH_B2;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_FETCH_B2: begin
                    operand[15:8] <= dataIn;
                    pc            <= pc + 16'd1;
                    instr_valid   <= 1'b1;
                    state         <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (go) begin
                        instr_valid <= 1'b0;
                        pc          <= use_load ? load_pc : pc;
                        if (nmi_pend) begin
                            vec      <= NMI_VEC;
                            vec_kind <= INT_NMI;
                            state    <= ST_VEC_LO;
                        end else if (irq_take) begin
                            vec      <= IRQ_VEC;
                            vec_kind <= INT_IRQ;
                            state    <= ST_VEC_LO;
                        end else begin
                            state <= ST_FETCH_OP;
                        end
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    vec         <= RESET_VEC;
                    vec_kind    <= INT_RESET;
                    state       <= ST_VEC_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit with a flat 64 KiB memory model.
module tb_cpu_fetch_unit;

    logic        clock;
    logic        reset;
    logic        irq;
    logic        nmi;
    logic [7:0]  dataIn;
    logic        irq_mask;
    logic        exec_done;
    logic        pc_load;
    logic [15:0] pc_new;
    logic [15:0] addressOut;
    logic        rw;
    logic        tick;
    logic        instr_valid;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [15:0] pc_out;
    logic [1:0]  int_kind;

    logic [7:0] mem [0:65535];
    int n_cmp = 0;
    int n_bad = 0;

    assign dataIn = mem[addressOut];

    cpu_fetch_unit #(.CLK_DIV(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .irq         (irq),
        .nmi         (nmi),
        .dataIn      (dataIn),
        .irq_mask    (irq_mask),
        .exec_done   (exec_done),
        .pc_load     (pc_load),
        .pc_new      (pc_new),
        .addressOut  (addressOut),
        .rw          (rw),
        .tick        (tick),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand),
        .pc_out      (pc_out),
        .int_kind    (int_kind)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Wait for the next tick, then one more clock so the new state is visible
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clock);
    endtask

    // Wait until an item is issued, counting the ticks on the way
    task automatic wait_issue(output bit ok, output int nt);
        ok = 1'b0;
        nt = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (tick) nt++;
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Align to a bus cycle, pulse exec_done for one clock, then let it take effect
    task automatic accept(input bit ld, input logic [15:0] np, output bit ok);
        bit ok1;
        wait_tick(ok1);
        exec_done = 1'b1;
        pc_load   = ld;
        pc_new    = np;
        @(negedge clock);
        exec_done = 1'b0;
        pc_load   = 1'b0;
        pc_new    = 16'h0000;
        wait_tick(ok);
        ok = ok & ok1;
    endtask

    task automatic test_reset;
        int n;
        bit ok;
        int nt;
        #3 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (addressOut !== 16'hFFFC) begin n_bad++; $display("FAIL rst_addr got %h want fffc", addressOut); end
        n_cmp++; if ({instr_valid, tick, rw} !== 3'b001) begin n_bad++; $display("FAIL rst_ctl got v/t/rw=%b want 001", {instr_valid, tick, rw}); end
        n_cmp++; if ({opcode, operand, pc_out, int_kind} !== 42'd0) begin n_bad++; $display("FAIL rst_data got op=%h opd=%h pc=%h k=%b want zeros", opcode, operand, pc_out, int_kind); end
        @(posedge clock);
        #1 reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n++;
            if (tick) break;
        end
        n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL first_tick got clock %0d want 12", n); end
        @(negedge clock);
        n_cmp++; if (addressOut !== 16'hFFFD) begin n_bad++; $display("FAIL vec_hi_addr got %h want fffd", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_issue_timeout got none want issue"); end
        n_cmp++; if (pc_out !== 16'h1234 || int_kind !== 2'b11) begin n_bad++; $display("FAIL rst_issue got pc=%h k=%b want 1234/11", pc_out, int_kind); end
        n_cmp++; if (opcode !== 8'h00 || operand !== 16'h0000) begin n_bad++; $display("FAIL rst_issue_op got %h/%h want 00/0000", opcode, operand); end
    endtask

    task automatic test_fetch_abs;
        bit ok;
        int nt;
        accept(1'b1, 16'h8000, ok);
        n_cmp++; if (!ok || addressOut !== 16'h8000 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL jump_8000 got addr=%h v=%b want 8000/0", addressOut, instr_valid); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || nt !== 3) begin n_bad++; $display("FAIL abs_ticks got %0d want 3", nt); end
        n_cmp++; if (opcode !== 8'hAD || operand !== 16'h2000 || pc_out !== 16'h8000 || int_kind !== 2'b00) begin n_bad++; $display("FAIL abs_issue got op=%h opd=%h pc=%h k=%b want ad/2000/8000/00", opcode, operand, pc_out, int_kind); end
        n_cmp++; if (addressOut !== 16'h8003) begin n_bad++; $display("FAIL abs_next got %h want 8003", addressOut); end
    endtask

    task automatic test_stall_and_jump;
        bit ok;
        int nt;
        int bad;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (instr_valid !== 1'b1 || opcode !== 8'hAD || operand !== 16'h2000 ||
                pc_out !== 16'h8000 || addressOut !== 16'h8003) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL stall_stable got %0d unstable clocks want 0", bad); end
        accept(1'b1, 16'hC000, ok);
        n_cmp++; if (!ok || addressOut !== 16'hC000) begin n_bad++; $display("FAIL jump_c000 got %h want c000", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || nt !== 2 || opcode !== 8'hA9 || operand !== 16'h0055 || pc_out !== 16'hC000) begin n_bad++; $display("FAIL imm_issue got op=%h opd=%h pc=%h t=%0d want a9/0055/c000/2", opcode, operand, pc_out, nt); end
    endtask

    task automatic test_wrap;
        bit ok;
        int nt;
        accept(1'b1, 16'hFFFF, ok);
        n_cmp++; if (!ok || addressOut !== 16'hFFFF) begin n_bad++; $display("FAIL jump_ffff got %h want ffff", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || opcode !== 8'hEA || operand !== 16'h0000 || pc_out !== 16'hFFFF) begin n_bad++; $display("FAIL nop_issue got op=%h opd=%h pc=%h want ea/0000/ffff", opcode, operand, pc_out); end
        n_cmp++; if (addressOut !== 16'h0000) begin n_bad++; $display("FAIL pc_wrap got %h want 0000", addressOut); end
        accept(1'b0, 16'h5555, ok);
        n_cmp++; if (!ok || addressOut !== 16'h0000) begin n_bad++; $display("FAIL fetch_0000 got %h want 0000", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || opcode !== 8'h20 || operand !== 16'h1234 || pc_out !== 16'h0000) begin n_bad++; $display("FAIL jsr_issue got op=%h opd=%h pc=%h want 20/1234/0000", opcode, operand, pc_out); end
    endtask

    task automatic test_nmi_irq;
        bit ok;
        int nt;
        @(negedge clock);
        nmi      = 1'b0;
        irq      = 1'b0;
        irq_mask = 1'b0;
        accept(1'b0, 16'h0000, ok);
        n_cmp++; if (!ok || addressOut !== 16'hFFFA || instr_valid !== 1'b0) begin n_bad++; $display("FAIL nmi_vec_lo got %h v=%b want fffa/0", addressOut, instr_valid); end
        wait_tick(ok);
        n_cmp++; if (!ok || addressOut !== 16'hFFFB) begin n_bad++; $display("FAIL nmi_vec_hi got %h want fffb", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || int_kind !== 2'b01 || pc_out !== 16'h9000 || opcode !== 8'h00) begin n_bad++; $display("FAIL nmi_issue got k=%b pc=%h op=%h want 01/9000/00", int_kind, pc_out, opcode); end
        nmi = 1'b1;
        accept(1'b0, 16'h0000, ok);
`ifdef NESCPU_IRQ_EN
        n_cmp++; if (!ok || addressOut !== 16'hFFFE) begin n_bad++; $display("FAIL irq_vec_lo got %h want fffe", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || int_kind !== 2'b10 || pc_out !== 16'hEA00) begin n_bad++; $display("FAIL irq_issue got k=%b pc=%h want 10/ea00", int_kind, pc_out); end
`else
        n_cmp++; if (!ok || addressOut !== 16'h9000) begin n_bad++; $display("FAIL irq_ignored got %h want 9000", addressOut); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || int_kind !== 2'b00 || opcode !== 8'h18 || pc_out !== 16'h9000) begin n_bad++; $display("FAIL clc_issue got k=%b op=%h pc=%h want 00/18/9000", int_kind, opcode, pc_out); end
`endif
        irq      = 1'b1;
        irq_mask = 1'b1;
    endtask

    task automatic test_reset_midfetch;
        bit ok;
        int nt;
        int n;
        accept(1'b1, 16'h8000, ok);
        wait_tick(ok);
        n_cmp++; if (!ok || addressOut !== 16'h8001 || opcode !== 8'hAD) begin n_bad++; $display("FAIL in_b1 got %h op=%h want 8001/ad", addressOut, opcode); end
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (addressOut !== 16'hFFFC || instr_valid !== 1'b0 || tick !== 1'b0 || rw !== 1'b1) begin n_bad++; $display("FAIL abort_ctl got addr=%h v=%b t=%b rw=%b want fffc/0/0/1", addressOut, instr_valid, tick, rw); end
        n_cmp++; if ({opcode, operand, pc_out, int_kind} !== 42'd0) begin n_bad++; $display("FAIL abort_data got op=%h opd=%h pc=%h k=%b want zeros", opcode, operand, pc_out, int_kind); end
        @(posedge clock);
        #1 reset = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n++;
            if (tick) break;
        end
        n_cmp++; if (n !== 12) begin n_bad++; $display("FAIL refetch_tick got clock %0d want 12", n); end
        wait_issue(ok, nt);
        n_cmp++; if (!ok || pc_out !== 16'h1234 || int_kind !== 2'b11) begin n_bad++; $display("FAIL refetch_issue got pc=%h k=%b want 1234/11", pc_out, int_kind); end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
        mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hEA;
        mem[16'h8000] = 8'hAD; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h20;
        mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h55;
        mem[16'h0000] = 8'h20; mem[16'h0001] = 8'h34; mem[16'h0002] = 8'h12;
        mem[16'h9000] = 8'h18;
        reset     = 1'b1;
        irq       = 1'b1;
        nmi       = 1'b1;
        irq_mask  = 1'b1;
        exec_done = 1'b0;
        pc_load   = 1'b0;
        pc_new    = 16'h0000;
        test_reset;
        test_fetch_abs;
        test_stall_and_jump;
        test_wrap;
        test_nmi_irq;
        test_reset_midfetch;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
